// File: rtl/wall_follow_pkg.sv
// Shared encodings for the wall-follower: drive commands, FSM states and the
// state-to-command mapping.
package wall_follow_pkg;

    typedef enum logic [2:0] {
        StIdle        = 3'd0,
        StFollow      = 3'd1,
        StSteerAway   = 3'd2,
        StSteerToward = 3'd3,
        StAvoid       = 3'd4,
        StEscape      = 3'd5
    } wf_state_e;

    typedef enum logic [2:0] {
        CmdStop    = 3'b000,
        CmdFwd     = 3'b001,
        CmdLeft    = 3'b010,
        CmdRight   = 3'b011,
        CmdReverse = 3'b100
    } drive_cmd_e;

    // side: 0 = left wall, 1 = right wall; "away" turns opposite to the wall.
    function automatic drive_cmd_e state_cmd(wf_state_e st, logic side);
        drive_cmd_e cmd;
        case (st)
            StFollow:              cmd = CmdFwd;
            StSteerAway, StAvoid:  cmd = side ? CmdLeft : CmdRight;
            StSteerToward:         cmd = side ? CmdRight : CmdLeft;
            StEscape:              cmd = CmdReverse;
            default:               cmd = CmdStop;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/wf_turn_timer.sv
// Down-counter used to hold the AVOID and ESCAPE manoeuvres for a minimum
// number of cycles.
module wf_turn_timer #(
    parameter int unsigned TURN_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam int unsigned TW = $clog2(TURN_CYCLES + 1);
    localparam logic [TW-1:0] LoadVal = TW'(TURN_CYCLES - 1);

    logic [TW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= LoadVal;
        end else if (dec && count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/wall_follower_fsm.sv
// Wall-following drive controller: classifies distance samples against a side
// band and front stop, and sequences follow / steer / avoid / escape manoeuvres.
module wall_follower_fsm
    import wall_follow_pkg::*;
#(
    parameter int unsigned DW          = 16,
    parameter int unsigned WALL_MIN    = 15,
    parameter int unsigned WALL_MAX    = 30,
    parameter int unsigned FRONT_STOP  = 20,
    parameter int unsigned HYST        = 2,
    parameter int unsigned PERSIST     = 4,
    parameter int unsigned TURN_CYCLES = 1000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          follow_side,
    input  logic          dist_valid,
    input  logic [DW-1:0] dist_left,
    input  logic [DW-1:0] dist_front,
    input  logic [DW-1:0] dist_right,
    output logic [2:0]    drive_cmd,
    output logic          cmd_valid,
    output logic [2:0]    state
);

    if (!(int'(WALL_MIN) + int'(HYST) < int'(WALL_MAX) - int'(HYST)) || PERSIST < 1 ||
        TURN_CYCLES < 1) begin : gen_param_check
        $error("wall_follower_fsm: inconsistent band, PERSIST or TURN_CYCLES parameters");
    end

    localparam int unsigned PW = $clog2(PERSIST + 1);
    localparam logic [DW-1:0] MinLim     = DW'(WALL_MIN);
    localparam logic [DW-1:0] MaxLim     = DW'(WALL_MAX);
    localparam logic [DW-1:0] FrontLim   = DW'(FRONT_STOP);
    localparam logic [DW-1:0] AwayExit   = DW'(WALL_MIN + HYST);
    localparam logic [DW-1:0] TowardExit = DW'(WALL_MAX - HYST);
    localparam logic [PW-1:0] PersistMax = PW'(PERSIST);

    wf_state_e  state_q, state_d;
    drive_cmd_e cmd_q, cmd_d;
    logic       cmd_valid_q;
    logic       side_q, side_d;
    logic       front_q;
    logic [PW-1:0] pcnt_q, pcnt_d, pcnt_inc;
    logic       cls_far_q, cls_far_d;
    logic [DW-1:0] side_dist, opp_dist;
    logic       front_block, near, far, opp_near, front_now, persisted;
    logic       tmr_zero, tmr_load, tmr_dec, tmr_clear;

    assign side_dist   = side_q ? dist_right : dist_left;
    assign opp_dist    = side_q ? dist_left : dist_right;
    assign front_block = (dist_front != '0) && (dist_front < FrontLim);
    assign near        = (side_dist != '0) && (side_dist < MinLim);
    assign far         = (side_dist == '0) || (side_dist > MaxLim);
    assign opp_near    = (opp_dist != '0) && (opp_dist < MinLim);
    assign front_now   = dist_valid ? front_block : front_q;

    // Run length of same-class samples, including the one presented this cycle.
    always_comb begin
        if (pcnt_q != '0 && cls_far_q == far) begin
            pcnt_inc = (pcnt_q == PersistMax) ? pcnt_q : pcnt_q + 1'b1;
        end else begin
            pcnt_inc = PW'(1);
        end
    end
    assign persisted = (near || far) && (pcnt_inc == PersistMax);

    always_comb begin
        state_d  = state_q;
        side_d   = side_q;
        tmr_load = 1'b0;
        if (!en) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d = StFollow;
                    side_d  = follow_side;
                end
                StFollow, StSteerAway, StSteerToward: begin
                    if (dist_valid) begin
                        if (front_block && opp_near) begin
                            state_d = StEscape;
                        end else if (front_block) begin
                            state_d = StAvoid;
                        end else if (state_q == StFollow) begin
                            if (persisted) state_d = near ? StSteerAway : StSteerToward;
                        end else if (state_q == StSteerAway) begin
                            if (side_dist >= AwayExit || side_dist == '0) state_d = StFollow;
                        end else if (side_dist != '0 && side_dist <= TowardExit) begin
                            state_d = StFollow;
                        end
                    end
                end
                StAvoid: begin
                    if (tmr_zero) begin
                        if (front_now) tmr_load = 1'b1;
                        else           state_d  = StFollow;
                    end
                end
                StEscape: begin
                    if (tmr_zero) state_d = StAvoid;
                end
                default: state_d = StIdle;
            endcase
            if ((state_d == StAvoid || state_d == StEscape) && state_d != state_q) begin
                tmr_load = 1'b1;
            end
        end
    end

    // Persistence only matters while following; any state change restarts it.
    always_comb begin
        pcnt_d    = pcnt_q;
        cls_far_d = cls_far_q;
        if (state_q != StFollow || state_d != state_q) begin
            pcnt_d = '0;
        end else if (dist_valid) begin
            if (near || far) begin
                pcnt_d    = pcnt_inc;
                cls_far_d = far;
            end else begin
                pcnt_d = '0;
            end
        end
    end

    assign cmd_d     = state_cmd(state_d, side_d);
    assign tmr_dec   = (state_q == StAvoid) || (state_q == StEscape);
    assign tmr_clear = !((state_d == StAvoid) || (state_d == StEscape));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cmd_q       <= CmdStop;
            cmd_valid_q <= 1'b0;
            side_q      <= 1'b0;
            front_q     <= 1'b0;
            pcnt_q      <= '0;
            cls_far_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= (cmd_d != cmd_q);
            side_q      <= side_d;
            if (dist_valid && state_q != StIdle) front_q <= front_block;
            pcnt_q      <= pcnt_d;
            cls_far_q   <= cls_far_d;
        end
    end

    wf_turn_timer #(
        .TURN_CYCLES(TURN_CYCLES)
    ) u_turn_timer (
        .clk  (clk),
        .rst  (rst),
        .clear(tmr_clear),
        .load (tmr_load),
        .dec  (tmr_dec),
        .zero (tmr_zero)
    );

    assign drive_cmd = cmd_q;
    assign cmd_valid = cmd_valid_q;
    assign state     = state_q;

endmodule

// File: tb/tb_wall_follower_fsm.sv
// Bench for wall_follower_fsm: table vectors, directed manoeuvre sequences and
// a random run checked against a behavioural model.
module tb_wall_follower_fsm;
    import wall_follow_pkg::*;

    localparam int DW = 16, WMIN = 15, WMAX = 30, FSTOP = 20, HYST = 2;
    localparam int PERSIST = 4, TURN = 8;

    logic clk = 1'b0;
    logic rst, en, follow_side, dist_valid;
    logic [DW-1:0] dist_left, dist_front, dist_right;
    logic [2:0] drive_cmd, state;
    logic cmd_valid;

    int total = 0;
    int bad = 0;
    bit use_model = 1'b0;

    always #5 clk = ~clk;

    wall_follower_fsm #(
        .DW(DW), .WALL_MIN(WMIN), .WALL_MAX(WMAX), .FRONT_STOP(FSTOP), .HYST(HYST),
        .PERSIST(PERSIST), .TURN_CYCLES(TURN)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .follow_side(follow_side), .dist_valid(dist_valid),
        .dist_left(dist_left), .dist_front(dist_front), .dist_right(dist_right),
        .drive_cmd(drive_cmd), .cmd_valid(cmd_valid), .state(state)
    );

    // Behavioural model: history queue of sample classes, up-counting dwell time.
    wf_state_e m_state = StIdle;
    logic m_side = 1'b0, m_front = 1'b0, m_cv = 1'b0;
    logic [2:0] m_cmd = 3'b000;
    int m_phase = 0;
    int hist[$];

    function automatic logic [2:0] exp_cmd(wf_state_e s, logic side);
        if (s == StFollow) return 3'b001;
        if (s == StEscape) return 3'b100;
        if (s == StSteerAway || s == StAvoid) return side ? 3'b010 : 3'b011;
        if (s == StSteerToward) return side ? 3'b011 : 3'b010;
        return 3'b000;
    endfunction

    task automatic model_edge();
        wf_state_e nxt;
        logic reload, fb, on, fnow;
        int s, o, cls;
        logic [2:0] ncmd;
        if (rst) begin
            m_state = StIdle; m_side = 1'b0; m_front = 1'b0; m_phase = 0;
            hist.delete(); m_cv = 1'b0; m_cmd = 3'b000;
            return;
        end
        s = m_side ? int'(dist_right) : int'(dist_left);
        o = m_side ? int'(dist_left) : int'(dist_right);
        fb = int'(dist_front) != 0 && int'(dist_front) < FSTOP;
        on = o != 0 && o < WMIN;
        cls = (s != 0 && s < WMIN) ? 1 : ((s == 0 || s > WMAX) ? 2 : 0);
        fnow = dist_valid ? fb : m_front;
        nxt = m_state;
        reload = 1'b0;
        if (!en) begin
            nxt = StIdle;
        end else begin
            case (m_state)
                StIdle: nxt = StFollow;
                StFollow, StSteerAway, StSteerToward: begin
                    if (dist_valid) begin
                        if (fb && on) nxt = StEscape;
                        else if (fb) nxt = StAvoid;
                        else if (m_state == StFollow) begin
                            if (cls == 0) hist.delete();
                            else begin
                                if (hist.size() > 0 && hist[$] != cls) hist.delete();
                                hist.push_back(cls);
                                if (hist.size() >= PERSIST)
                                    nxt = (cls == 1) ? StSteerAway : StSteerToward;
                            end
                        end else if (m_state == StSteerAway) begin
                            if (s >= WMIN + HYST || s == 0) nxt = StFollow;
                        end else if (s != 0 && s <= WMAX - HYST) nxt = StFollow;
                    end
                end
                StAvoid: if (m_phase >= TURN) begin
                    if (fnow) reload = 1'b1;
                    else nxt = StFollow;
                end
                StEscape: if (m_phase >= TURN) nxt = StAvoid;
                default: nxt = StIdle;
            endcase
        end
        if (m_state == StIdle && en) m_side = follow_side;
        if (dist_valid && m_state != StIdle) m_front = fb;
        if (nxt != m_state) hist.delete();
        if (nxt == StAvoid || nxt == StEscape)
            m_phase = (nxt != m_state || reload) ? 1 : m_phase + 1;
        else
            m_phase = 0;
        ncmd = exp_cmd(nxt, m_side);
        m_cv = (ncmd != m_cmd);
        m_cmd = ncmd;
        m_state = nxt;
    endtask

    task automatic check(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, want);
        end
    endtask

    task automatic expect3(input string name, input wf_state_e st, input logic [2:0] cmd,
                           input logic cv);
        check({name, "_state"}, int'(state), int'(st));
        check({name, "_cmd"}, int'(drive_cmd), int'(cmd));
        check({name, "_cv"}, int'(cmd_valid), int'(cv));
    endtask

    // Apply one cycle of inputs; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic r, input logic e, input logic sd, input logic dv,
                        input int l, input int f, input int rv);
        rst = r; en = e; follow_side = sd; dist_valid = dv;
        dist_left = DW'(l); dist_front = DW'(f); dist_right = DW'(rv);
        model_edge();
        @(posedge clk);
        #1;
        if (use_model) begin
            check("model_state", int'(state), int'(m_state));
            check("model_cmd", int'(drive_cmd), int'(m_cmd));
            check("model_cv", int'(cmd_valid), int'(m_cv));
        end
    endtask

    task automatic hold(input string name, input int n, input wf_state_e st,
                        input logic [2:0] cmd);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 20, 50, 50);
            expect3($sformatf("%s%0d", name, i), st, cmd, 1'b0);
        end
    endtask

    typedef struct {
        logic rst, en, side, dv;
        int l, f, r;
        wf_state_e st;
        logic [2:0] cmd;
        logic cv;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic r, logic e, logic sd, logic dv, int l, int f, int rv,
                                wf_state_e st, logic [2:0] cmd, logic cv);
        vec_t v;
        v.rst = r; v.en = e; v.side = sd; v.dv = dv; v.l = l; v.f = f; v.r = rv;
        v.st = st; v.cmd = cmd; v.cv = cv;
        tbl.push_back(v);
    endfunction

    function automatic int walk(int v, int lo, int hi);
        int n;
        n = v + int'($urandom_range(0, 6)) - 3;
        if ($urandom_range(0, 19) == 0) n = 0;
        if (n < lo) n = lo;
        if (n > hi) n = hi;
        return n;
    endfunction

    initial begin
        int lw, fw, rw;
        rst = 1'b1; en = 1'b0; follow_side = 1'b0; dist_valid = 1'b0;
        dist_left = '0; dist_front = '0; dist_right = '0;

        add(1, 0, 0, 0, 0, 0, 0, StIdle, 3'b000, 0);
        add(0, 1, 0, 0, 0, 0, 0, StFollow, 3'b001, 1);
        add(0, 1, 0, 1, 20, 50, 50, StFollow, 3'b001, 0);
        add(0, 1, 0, 0, 20, 50, 50, StFollow, 3'b001, 0);
        add(0, 1, 0, 1, 20, 50, 50, StFollow, 3'b001, 0);
        add(0, 1, 0, 1, 10, 50, 50, StFollow, 3'b001, 0);
        add(0, 1, 0, 0, 10, 50, 50, StFollow, 3'b001, 0);
        add(0, 1, 0, 1, 10, 50, 50, StFollow, 3'b001, 0);
        add(0, 1, 0, 1, 10, 50, 50, StFollow, 3'b001, 0);
        add(0, 1, 0, 1, 10, 50, 50, StSteerAway, 3'b011, 1);
        add(0, 1, 0, 1, 16, 50, 50, StSteerAway, 3'b011, 0);
        add(0, 1, 0, 1, 17, 50, 50, StFollow, 3'b001, 1);
        for (int i = 0; i < 3; i++) add(0, 1, 0, 1, 0, 50, 50, StFollow, 3'b001, 0);
        add(0, 1, 0, 1, 0, 50, 50, StSteerToward, 3'b010, 1);
        add(0, 1, 0, 1, 29, 50, 50, StSteerToward, 3'b010, 0);
        add(0, 1, 0, 1, 28, 50, 50, StFollow, 3'b001, 1);
        add(0, 0, 0, 0, 28, 50, 50, StIdle, 3'b000, 1);
        add(0, 1, 0, 0, 20, 50, 50, StFollow, 3'b001, 1);
        for (int i = 0; i < 3; i++) add(0, 1, 0, 1, 10, 50, 50, StFollow, 3'b001, 0);
        add(0, 1, 0, 1, 0, 50, 50, StFollow, 3'b001, 0);
        for (int i = 0; i < 3; i++) add(0, 1, 0, 1, 10, 50, 50, StFollow, 3'b001, 0);
        add(0, 1, 0, 1, 10, 50, 50, StSteerAway, 3'b011, 1);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].en, tbl[i].side, tbl[i].dv, tbl[i].l, tbl[i].f, tbl[i].r);
            expect3($sformatf("tbl%0d", i), tbl[i].st, tbl[i].cmd, tbl[i].cv);
        end

        // AVOID with front clear, then AVOID with front still blocked at timeout.
        step(1, 0, 0, 0, 20, 50, 50);  expect3("av_rst", StIdle, 3'b000, 0);
        step(0, 1, 0, 0, 20, 50, 50);  expect3("av_en", StFollow, 3'b001, 1);
        step(0, 1, 0, 1, 20, 19, 50);  expect3("av_in", StAvoid, 3'b011, 1);
        step(0, 1, 0, 1, 20, 25, 50);  expect3("av_clr", StAvoid, 3'b011, 0);
        hold("av_hold", 6, StAvoid, 3'b011);
        step(0, 1, 0, 0, 20, 50, 50);  expect3("av_out", StFollow, 3'b001, 1);
        step(0, 1, 0, 1, 20, 19, 50);  expect3("avb_in", StAvoid, 3'b011, 1);
        hold("avb_hold", 7, StAvoid, 3'b011);
        step(0, 1, 0, 1, 20, 19, 50);  expect3("avb_reload", StAvoid, 3'b011, 0);
        step(0, 1, 0, 1, 20, 25, 50);  expect3("avb_clr", StAvoid, 3'b011, 0);
        hold("avb_hold2", 6, StAvoid, 3'b011);
        step(0, 1, 0, 0, 20, 50, 50);  expect3("avb_out", StFollow, 3'b001, 1);

        // ESCAPE into AVOID, then reset mid-turn.
        step(0, 1, 0, 1, 20, 10, 5);   expect3("esc_in", StEscape, 3'b100, 1);
        hold("esc_hold", 7, StEscape, 3'b100);
        step(0, 1, 0, 0, 20, 50, 50);  expect3("esc_av", StAvoid, 3'b011, 1);
        hold("esc_av_hold", 3, StAvoid, 3'b011);
        step(1, 1, 0, 0, 20, 50, 50);  expect3("mid_rst0", StIdle, 3'b000, 0);
        step(1, 1, 0, 0, 20, 50, 50);  expect3("mid_rst1", StIdle, 3'b000, 0);
        step(0, 1, 0, 0, 20, 50, 50);  expect3("post_rst", StFollow, 3'b001, 1);

        // en low mid-AVOID returns to IDLE at once.
        step(0, 1, 0, 1, 20, 19, 50);  expect3("en_av", StAvoid, 3'b011, 1);
        step(0, 0, 0, 0, 20, 50, 50);  expect3("en_off", StIdle, 3'b000, 1);

        // Right wall latched; follow_side input changes afterwards are ignored.
        step(1, 0, 0, 0, 50, 50, 50);  expect3("r_rst", StIdle, 3'b000, 0);
        step(0, 1, 1, 0, 50, 50, 50);  expect3("r_en", StFollow, 3'b001, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 1, 50, 50, 0);
            expect3($sformatf("r_far%0d", i), StFollow, 3'b001, 0);
        end
        step(0, 1, 0, 1, 50, 50, 0);   expect3("r_tow", StSteerToward, 3'b011, 1);
        step(0, 1, 0, 1, 50, 50, 29);  expect3("r_tow29", StSteerToward, 3'b011, 0);
        step(0, 1, 0, 1, 50, 50, 28);  expect3("r_tow28", StFollow, 3'b001, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 1, 50, 50, 10);
            expect3($sformatf("r_near%0d", i), StFollow, 3'b001, 0);
        end
        step(0, 1, 0, 1, 50, 50, 10);  expect3("r_away", StSteerAway, 3'b010, 1);

        // Random run against the model, starting from a clean reset.
        step(1, 0, 0, 0, 0, 0, 0);
        use_model = 1'b1;
        lw = 20; fw = 40; rw = 20;
        for (int i = 0; i < 4000; i++) begin
            lw = walk(lw, 0, 40);
            rw = walk(rw, 0, 40);
            fw = walk(fw, 0, 60);
            step(logic'($urandom_range(0, 299) == 0), logic'($urandom_range(0, 59) != 0),
                 logic'($urandom_range(0, 1)), logic'($urandom_range(0, 2) == 0), lw, fw, rw);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wall_follower_fsm.md
WALL_FOLLOWER_FSM -- requirements
Module: wall_follower_fsm

Interface
REQ-001 Parameter DW, default 16: width of every distance input.
REQ-002 Parameters WALL_MIN 15, WALL_MAX 30, FRONT_STOP 20: side band low/high limits and front stop distance, in sensor units.
REQ-003 Parameter HYST, default 2: exit margin applied to the side band.
REQ-004 Parameter PERSIST, default 4: number of consecutive qualifying samples needed to enter a steer state.
REQ-005 Parameter TURN_CYCLES, default 1000: minimum clk cycles spent in AVOID and ESCAPE.
REQ-006 clk  in  1  single clock; all logic on its rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 en  in  1  1 = run, 0 = return to IDLE.
REQ-009 follow_side  in  1  0 = follow the left wall, 1 = follow the right wall.
REQ-010 dist_valid  in  1  one-cycle strobe; the three distances are valid in this cycle.
REQ-011 dist_left, dist_front, dist_right  in  DW each  distances; 0 = no echo (far).
REQ-012 drive_cmd  out  3  000 STOP, 001 FWD, 010 LEFT, 011 RIGHT, 100 REVERSE.
REQ-013 cmd_valid  out  1  one-cycle pulse in the cycle drive_cmd takes a new value.
REQ-014 state  out  3  current FSM state, for debug.

Function
REQ-015 Terms: wall side = latched follow_side sensor; "away" = turn opposite to the wall side (left wall -> RIGHT); "toward" = turn to the wall side.
REQ-016 Classification per valid sample: front_block = F!=0 && F<FRONT_STOP; near = S!=0 && S<WALL_MIN; far = S==0 || S>WALL_MAX; opp_near = opposite-side sensor !=0 && <WALL_MIN.
REQ-017 States: IDLE (STOP), FOLLOW (FWD), STEER_AWAY (away), STEER_TOWARD (toward), AVOID (away), ESCAPE (REVERSE).
REQ-018 drive_cmd and state are registered and update on the same edge; the response to a sample appears 1 cycle after its dist_valid cycle.
REQ-019 IDLE: en=1 -> FOLLOW; follow_side is latched on this transition and is ignored until the next IDLE.
REQ-020 en=0 in any state -> IDLE on the next edge, with priority over all other transitions.
REQ-021 FOLLOW, on a valid sample, priority order: front_block && opp_near -> ESCAPE; front_block -> AVOID; near persisted -> STEER_AWAY; far persisted -> STEER_TOWARD.
REQ-022 Persistence counter: counts consecutive valid samples with the same near/far class and saturates at PERSIST; it clears on a class change, a sample that is in band, and any state change.
REQ-023 STEER_AWAY: exit to FOLLOW on the first sample with S>=WALL_MIN+HYST or S==0.
REQ-024 STEER_TOWARD: exit to FOLLOW on the first sample with S!=0 && S<=WALL_MAX-HYST.
REQ-025 In either steer state, front_block preempts the exit rules using the REQ-021 order.
REQ-026 AVOID: load the timer with TURN_CYCLES-1 on entry and decrement it every cycle; at 0, go to FOLLOW if the last sample was not front_block, otherwise reload the timer and stay.
REQ-027 ESCAPE: run the same timer; at 0, go to AVOID unconditionally.
REQ-028 dist_valid is ignored in IDLE and ignored by transition logic while the timer is non-zero; the last-sample front flag still updates.
REQ-029 Timer width is $clog2(TURN_CYCLES+1); an elaboration error is raised unless WALL_MIN+HYST < WALL_MAX-HYST, PERSIST>=1 and TURN_CYCLES>=1.

Reset
REQ-030 While rst=1: state=IDLE, drive_cmd=STOP, cmd_valid=0, timer=0, persistence counter=0, latched side=0; this applies in every state, including mid-turn.

Structure
REQ-031 Package wall_follow_pkg holds the drive_cmd encodings and the state enum.
REQ-032 Sub-module wf_turn_timer (load, decrement, zero flag) is instantiated once.

Verification (PERSIST=4, TURN_CYCLES=8, HYST=2)
REQ-033 rst pulsed for 2 cycles mid-AVOID -> drive_cmd=000, cmd_valid=0, state=IDLE on the next edge.
REQ-034 en=1, side=0, L=20 F=50 R=50 -> FWD with one cmd_valid pulse; a further identical sample -> no pulse.
REQ-035 L=10 for 3 samples -> FWD held; 4th sample -> RIGHT; L=16 -> RIGHT held; L=17 -> FWD.
REQ-036 FOLLOW, F=19 -> RIGHT 1 cycle later, held at least 8 cycles; F=25 then timer at 0 -> FWD.
REQ-037 side=0, F=10 R=5 -> REVERSE for 8 cycles, then RIGHT (AVOID).
REQ-038 side=1, R=0 for 4 samples -> RIGHT (toward); R=29 -> RIGHT held; R=28 -> FWD.
